// File: rtl/conf_int_mul__stim_pkg.sv
// conf_int_mul__stim_pkg: shared FSM states and maximal-length Galois polynomials for the stimulus block
package conf_int_mul__stim_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_DONE} stim_state_t;
  function automatic logic [31:0] poly_for_width(input int w);
    return w == 6  ? 32'h0000_0021 :
           w == 8  ? 32'h0000_0071 :
           w == 14 ? 32'h0000_3005 :
           w == 16 ? 32'h0000_A011 :
           w == 22 ? 32'h0020_0001 :
           w == 24 ? 32'h00C2_0001 :
           w == 30 ? 32'h0000_0053 :
           w == 32 ? 32'h0040_0007 : 32'h0;
  endfunction
endpackage

// File: rtl/conf_int_mul__galois_lfsr.sv
// conf_int_mul__galois_lfsr: left-shifting Galois LFSR, doubles as a MISR when inject is non-zero
module conf_int_mul__galois_lfsr #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] inject,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (load) q <= load_val;
    else if (step) q <= {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ inject;
endmodule

// File: rtl/conf_int_mul__op_driver_sig_collector.sv
// conf_int_mul__op_driver_sig_collector: drives LFSR operands into the multiplier and compacts its results into a MISR
module conf_int_mul__op_driver_sig_collector
  import conf_int_mul__stim_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int OP_BITWIDTH        = 16,
  parameter int NUM_VECTORS        = 256,
  parameter int SETTLE_CYCLES      = 2,
  parameter int SEED_A             = 1,
  parameter int SEED_B             = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [DATA_PATH_BITWIDTH-1:0] a_out,
  output logic [DATA_PATH_BITWIDTH-1:0] b_out,
  input  logic [DATA_PATH_BITWIDTH-3:0] d_in,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_PATH_BITWIDTH-3:0] signature,
  output logic [15:0]                   vec_count
);
  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int W  = DW - 2;
  localparam logic [31:0]   POLY_OP_FULL   = poly_for_width(DW);
  localparam logic [31:0]   POLY_MISR_FULL = poly_for_width(W);
  localparam logic [DW-1:0] POLY_OP        = POLY_OP_FULL[DW-1:0];
  localparam logic [W-1:0]  POLY_MISR      = POLY_MISR_FULL[W-1:0];
  localparam logic [63:0]   OPMASK_FULL    = (64'd1 << OP_BITWIDTH) - 64'd1;
  localparam logic [DW-1:0] OPMASK         = OPMASK_FULL[DW-1:0];
  localparam logic [DW-1:0] SA_RAW         = SEED_A[DW-1:0];
  localparam logic [DW-1:0] SB_RAW         = SEED_B[DW-1:0];
  localparam logic [DW-1:0] SA             = SA_RAW == '0 ? '1 : SA_RAW;
  localparam logic [DW-1:0] SB             = SB_RAW == '0 ? '1 : SB_RAW;
  localparam logic [15:0]   NV             = 16'(NUM_VECTORS);
  localparam logic [7:0]    SC             = 8'(SETTLE_CYCLES);
  stim_state_t   state, state_nx;
  logic [7:0]    settle_cnt;
  logic [DW-1:0] lfsr_a, lfsr_b;
  logic          seed_load, capture, last_vec;
  always_ff @(posedge clk) state <= !rst ? S_IDLE : state_nx;
  always_comb begin
    seed_load = start && (state == S_IDLE || state == S_DONE);
    capture   = state == S_CAPTURE;
    last_vec  = vec_count + 16'd1 == NV;
    busy      = state == S_DRIVE || state == S_SETTLE || capture;
    state_nx  = seed_load ? S_DRIVE :
                state == S_DRIVE ? (SC == 8'd0 ? S_CAPTURE : S_SETTLE) :
                state == S_SETTLE && settle_cnt == 8'd0 ? S_CAPTURE :
                capture ? (last_vec ? S_DONE : S_DRIVE) : state;
  end
  // done is registered so it trails entry into DONE by one cycle
  always_ff @(posedge clk)
    if (!rst) begin
      a_out      <= '0;
      b_out      <= '0;
      settle_cnt <= '0;
      vec_count  <= '0;
      done       <= 1'b0;
    end else begin
      done <= state == S_DONE;
      if (state == S_DRIVE) begin
        a_out      <= lfsr_a & OPMASK;
        b_out      <= lfsr_b & OPMASK;
        settle_cnt <= SC - 8'd1;
      end
      if (state == S_SETTLE) settle_cnt <= settle_cnt - 8'd1;
      if (seed_load) vec_count <= '0;
      else if (capture) vec_count <= vec_count + 16'd1;
    end
  conf_int_mul__galois_lfsr #(.WIDTH(DW), .POLY(POLY_OP)) u_lfsr_a (
    .clk(clk), .rst(rst), .load(seed_load), .load_val(SA), .step(capture), .inject('0), .q(lfsr_a)
  );
  conf_int_mul__galois_lfsr #(.WIDTH(DW), .POLY(POLY_OP)) u_lfsr_b (
    .clk(clk), .rst(rst), .load(seed_load), .load_val(SB), .step(capture), .inject('0), .q(lfsr_b)
  );
  conf_int_mul__galois_lfsr #(.WIDTH(W), .POLY(POLY_MISR)) u_misr (
    .clk(clk), .rst(rst), .load(seed_load), .load_val('0), .step(capture), .inject(d_in), .q(signature)
  );
endmodule
